sequential_restoring_divider: RTL and testbench
===============================================

SEQUENTIAL_RESTORING_DIVIDER -- requirements
Module: sequential_restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only when ready.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; sampled on the accepting edge only.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge only.
REQ-007 SHALL have port ready  output  1  high in IDLE and DONE states; the block accepts start when high.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient, registered.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder, registered.
REQ-011 SHALL have port div_by_zero  output  1  high with done when the accepted divisor was 0.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, plus an iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-013 SHALL accept a request on an edge where start=1 and ready=1, and on that edge latch both operands, clear the partial remainder, load counter=WIDTH and enter RUN.
REQ-014 SHALL, on an accepting edge with divisor=0, skip RUN, enter DONE, and set quotient to all ones, remainder to dividend and div_by_zero to 1.
REQ-015 SHALL, on each RUN edge, shift {partial remainder, dividend register} left by one and form trial = shifted remainder - divisor using a (WIDTH+1)-bit ripple subtraction (inverted divisor, carry-in 1).
REQ-016 SHALL, when the trial does not borrow, load trial into the partial remainder and shift 1 into the quotient LSB; otherwise SHALL keep the shifted remainder and shift in 0 (restoring).
REQ-017 SHALL decrement the counter on every RUN edge and, on the edge where it reaches 0, move to DONE with final quotient and remainder registered.
REQ-018 SHALL assert done exactly WIDTH rising edges after the accepting edge for a nonzero divisor, and exactly 1 edge after it for a zero divisor.
REQ-019 SHALL hold done high for one cycle only; from DONE it SHALL return to IDLE, or re-enter RUN/DONE if start=1 on that edge.
REQ-020 SHALL keep quotient, remainder and div_by_zero stable from done until the next accepting edge, and SHALL clear div_by_zero on every accepting edge with a nonzero divisor.
REQ-021 SHALL ignore start while in RUN; operand input changes during RUN SHALL NOT affect the result.
REQ-022 SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.

Reset
REQ-023 SHALL, on any edge with rst=1, enter IDLE and drive ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, overriding start.
REQ-024 SHALL, on reset asserted during RUN, abandon the operation without a done pulse.
REQ-025 SHALL resume normal operation on the first edge with rst=0, where start is honoured.

Verification
REQ-026 SHALL cover: WIDTH=4, 13/4 -> done 4 edges after accept, quotient=3, remainder=1, div_by_zero=0.
REQ-027 SHALL cover: 15/1 -> quotient=15, remainder=0; and 5/7 -> quotient=0, remainder=5.
REQ-028 SHALL cover: 9/0 -> done 1 edge after accept, quotient=15, remainder=9, div_by_zero=1; then 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-029 SHALL cover: 12/5 accepted, then start=1 with 1/1 two cycles later -> second start ignored, results quotient=2, remainder=2.
REQ-030 SHALL cover: rst=1 on the 2nd RUN edge of 14/3 -> no done pulse, all outputs 0, ready=1; the following 14/3 -> quotient=4, remainder=2.
REQ-031 SHALL cover: back-to-back start held high in the DONE cycle -> second division accepted with no idle gap, plus an exhaustive WIDTH=4 sweep checked against REQ-022.

Source files
------------

// File: rtl/sequential_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// with a start/ready/done handshake and divide-by-zero flagging.
module sequential_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_res;
  logic [WIDTH-1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Ripple subtraction a - b as a + ~b + 1; returns {borrow, low WIDTH diff bits}.
  // The top bit only feeds the final carry since a successful trial fits in WIDTH bits.
  function automatic logic [WIDTH:0] ripple_sub(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b);
    logic             c;
    logic             bi;
    logic [WIDTH-1:0] d;
    c = 1'b1;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bi   = ~b[i];
      d[i] = a[i] ^ bi ^ c;
      c    = (a[i] & bi) | (a[i] & c) | (bi & c);
    end
    bi = ~b[WIDTH];
    c  = (a[WIDTH] & bi) | (a[WIDTH] & c) | (bi & c);
    return {~c, d};
  endfunction

  always_comb begin
    shifted  = {part_rem, dvd_reg[WIDTH-1]};
    sub_res  = ripple_sub(shifted, {1'b0, dvs_reg});
    borrow   = sub_res[WIDTH];
    trial    = sub_res[WIDTH-1:0];
    rem_next = borrow ? shifted[WIDTH-1:0] : trial;
    quo_next = {dvd_reg[WIDTH-2:0], ~borrow};
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign done  = (state == DONE);

  // The dividend register doubles as the quotient shift register; the output
  // registers only change at completion (or at acceptance for a zero divisor).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      part_rem    <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_reg  <= dividend;
            dvs_reg  <= divisor;
            part_rem <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              count       <= '0;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              count       <= COUNT_INIT;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part_rem <= rem_next;
          dvd_reg  <= quo_next;
          count    <= count - 1'b1;
          if (count == CW'(1)) begin
            state     <= DONE;
            quotient  <= quo_next;
            remainder <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// Randomized and directed bench for sequential_restoring_divider: stimulus
// pushes arithmetic-model results into a queue, a monitor checks each done.
module tb_sequential_restoring_divider;

  localparam int W = 4;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int done_cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  exp_t exp_q[$];

  sequential_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: plain integer division; zero divisor yields all-ones quotient.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.dbz = 1;
      e.done_cycle = acc;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 0;
      e.done_cycle = acc + W;
    end
    return e;
  endfunction

  // Monitor: each done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("quotient", 32'(quotient), 32'(e.q));
        checkOutput("remainder", 32'(remainder), 32'(e.r));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        checkOutput("done_latency", 32'(cycle), 32'(e.done_cycle));
        if (e.b != 0)
          checkOutput("identity", 32'(int'(quotient) * e.b + int'(remainder)), 32'(e.a));
      end
    end
  end

  // Waits for ready, presents one request and returns the accepting cycle.
  task automatic applyStimulus(input int a, input int b, input bit expect_result,
                               output int acc);
    int waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      checkOutput("ready_timeout", 32'(ready), 32'd1);
      acc = -1;
      return;
    end
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    acc      = cycle;
    start    = 1'b0;
    dividend = W'($urandom_range((1 << W) - 1));
    divisor  = W'($urandom_range((1 << W) - 1));
    if (expect_result) exp_q.push_back(model(a, b, acc));
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int acc2;

    // Reset overrides a pending start.
    rst = 1'b1;
    start = 1'b1;
    dividend = 4'd9;
    divisor = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quotient", 32'(quotient), 32'd0);
    checkOutput("rst_remainder", 32'(remainder), 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    start = 1'b0;

    applyStimulus(13, 4, 1, acc);
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("hold_quotient", 32'(quotient), 32'd3);
    checkOutput("hold_remainder", 32'(remainder), 32'd1);

    applyStimulus(15, 1, 1, acc);
    applyStimulus(5, 7, 1, acc);
    applyStimulus(9, 0, 1, acc);
    applyStimulus(8, 2, 1, acc);
    waitDrain();

    // A start pulse and operand changes during RUN must be ignored.
    applyStimulus(12, 5, 1, acc);
    @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain();

    // Reset on the second RUN edge abandons the division silently.
    applyStimulus(14, 3, 0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", 32'(quotient), 32'd0);
    checkOutput("abort_remainder", 32'(remainder), 32'd0);
    checkOutput("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (W + 2) @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model(14, 3, cycle));
    waitDrain();

    // Back-to-back requests: the second is accepted on the DONE edge.
    applyStimulus(7, 2, 1, acc);
    applyStimulus(6, 3, 1, acc2);
    checkOutput("no_idle_gap", 32'(acc2), 32'(acc + W + 1));
    waitDrain();

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        applyStimulus(a, b, 1, acc);
    waitDrain();

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      applyStimulus(int'($urandom_range((1 << W) - 1)),
                    int'($urandom_range((1 << W) - 1)), 1, acc);
    end
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
